// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back arbiter.
//   wb_req_t : one register-file write (destination + data)
//   REG_ZERO : x0, never written
//   XLEN     : register width
package wb_pkg;
  localparam int         XLEN     = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t.
//   clk, rst_n   : clock, async active-low reset (empties the FIFO)
//   push, din    : write din at posedge (caller guarantees !full)
//   pop          : drop head at posedge (caller guarantees !empty)
//   head         : current oldest entry
//   full, empty  : occupancy flags
//   count        : number of queued entries
//   vld, rd_vec  : per-slot valid bit and destination, for pending-register masks
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_req_t               din,
  input  logic                  pop,
  output wb_req_t               head,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count,
  output logic [DEPTH-1:0]      vld,
  output logic [DEPTH-1:0][4:0] rd_vec
);

  logic [AW-1:0]    wp, rp;
  logic [AW:0]      cnt;
  logic [DEPTH-1:0] vld_q, set_oh, clr_oh;
  wb_req_t          mem [DEPTH];

  localparam logic [DEPTH-1:0] ONE = {{(DEPTH-1){1'b0}}, 1'b1};

  assign set_oh = push ? (ONE << wp) : '0;
  assign clr_oh = pop  ? (ONE << rp) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      cnt   <= '0;
      vld_q <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // wp != rp whenever push and pop coincide (neither empty nor full)
      vld_q <= (vld_q & ~clr_oh) | set_oh;
    end
  end

  // Payload needs no reset: vld_q gates every use of it.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  assign head  = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign vld   = vld_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_rd
    assign rd_vec[i] = mem[i].rd;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file's single write port.
// Pipeline write-backs always win; long-latency results queue in wb_fifo and
// drain into idle slots. A head that waits too long raises stall_req to get
// one pipeline bubble.
//   clk, rst_n                 : clock, async active-low reset
//   pipe_we/pipe_rd/pipe_wd    : in-order pipeline write-back
//   lu_valid/lu_ready/lu_rd/lu_wd : long-latency result handshake
//   a3/wd3/we3                 : register file write port
//   stall_req                  : ask the pipeline for one bubble
//   pend_mask                  : registers targeted by queued results
//   fifo_count                 : queued entry count
module wb_arbiter
  import wb_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  int STARVE_LIMIT = 8,
  localparam int CW           = $clog2(DEPTH) + 1,
  localparam int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_we,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wd,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_wd,
  output logic [4:0]      a3,
  output logic [XLEN-1:0] wd3,
  output logic            we3,
  output logic            stall_req,
  output logic [31:0]     pend_mask,
  output logic [CW-1:0]   fifo_count
);

  logic                  pipe_slot, f_push, f_pop, full, empty;
  wb_req_t               head;
  logic [DEPTH-1:0]      vld;
  logic [DEPTH-1:0][4:0] rd_vec;
  logic [SW-1:0]         starve;

  // x0 writes from the pipeline are free slots for the queue.
  assign pipe_slot = pipe_we && (pipe_rd != REG_ZERO);
  assign lu_ready  = rst_n && !full;
  // rd=0 results complete the handshake but are dropped.
  assign f_push    = lu_valid && lu_ready && (lu_rd != REG_ZERO);
  assign f_pop     = !pipe_slot && !empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (f_push),
    .din    ('{rd: lu_rd, data: lu_wd}),
    .pop    (f_pop),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (fifo_count),
    .vld    (vld),
    .rd_vec (rd_vec)
  );

  // Port mux; held quiet during reset so no pipeline write slips through.
  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    wd3 = '0;
    if (rst_n) begin
      if (pipe_slot) begin
        we3 = 1'b1;
        a3  = pipe_rd;
        wd3 = pipe_wd;
      end else if (!empty) begin
        we3 = 1'b1;
        a3  = head.rd;
        wd3 = head.data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         starve <= '0;
    else if (empty || f_pop)            starve <= '0;
    else if (starve != SW'(STARVE_LIMIT)) starve <= starve + 1'b1;
  end

  assign stall_req = (starve == SW'(STARVE_LIMIT));

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i]) pend_mask[rd_vec[i]] = 1'b1;
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic        clk, rst_n;
  logic        pipe_we, lu_valid, lu_ready, we3, stall_req;
  logic [4:0]  pipe_rd, lu_rd, a3;
  logic [31:0] pipe_wd, lu_wd, wd3, pend_mask;
  logic [2:0]  fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wd(lu_wd),
    .a3(a3), .wd3(wd3), .we3(we3), .stall_req(stall_req),
    .pend_mask(pend_mask), .fifo_count(fifo_count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an ordered list of queued results plus an age counter.
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t q[$];
  int   starve;

  logic        cap_we3, cap_rdy, cap_stall;
  logic [4:0]  cap_a3;
  logic [31:0] cap_wd3, cap_pend;
  logic [2:0]  cap_cnt;

  // Called at posedge+1; drives one cycle, checks at negedge, ends at posedge+1.
  task automatic cyc(input logic pwe, input logic [4:0] prd, input logic [31:0] pwd,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    logic        ps, e_we, e_rdy, popped, acc;
    logic [4:0]  e_a;
    logic [31:0] e_wd, e_pend;
    int          sz0;
    pipe_we = pwe; pipe_rd = prd; pipe_wd = pwd;
    lu_valid = lv; lu_rd = lrd; lu_wd = lwd;
    @(negedge clk);
    ps = pwe && (prd != 0);
    sz0 = q.size();
    e_we = 0; e_a = 0; e_wd = 0;
    if (ps) begin e_we = 1; e_a = prd; e_wd = pwd; end
    else if (sz0 > 0) begin e_we = 1; e_a = q[0].rd; e_wd = q[0].d; end
    e_rdy = (sz0 < DEPTH);
    e_pend = 0;
    foreach (q[i]) e_pend[q[i].rd] = 1'b1;
    check("we3", we3, e_we);
    check("a3", a3, e_a);
    check("wd3", wd3, e_wd);
    check("lu_ready", lu_ready, e_rdy);
    check("fifo_count", fifo_count, sz0);
    check("stall_req", stall_req, starve == LIM);
    check("pend_mask", pend_mask, e_pend);
    cap_we3 = we3; cap_a3 = a3; cap_wd3 = wd3; cap_rdy = lu_ready;
    cap_cnt = fifo_count; cap_stall = stall_req; cap_pend = pend_mask;
    popped = !ps && sz0 > 0;
    acc = lv && e_rdy && lrd != 0;
    if (popped) void'(q.pop_front());
    if (acc) q.push_back('{lrd, lwd});
    if (sz0 == 0 || popped) starve = 0;
    else if (starve < LIM) starve++;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    pipe_we = 0; pipe_rd = 0; pipe_wd = 0; lu_valid = 0; lu_rd = 0; lu_wd = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    q.delete(); starve = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic pwe; logic [4:0] prd; logic [31:0] pwd;
    logic lv;  logic [4:0] lrd; logic [31:0] lwd;
    logic ewe; logic [4:0] ea;  logic [31:0] ewd; logic [2:0] ecnt; logic [31:0] epend;
  } vec_t;
  vec_t tbl[8];

  int first_stall;

  initial begin
    tbl[0] = '{0, 0, 0,        1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0};
    tbl[1] = '{0, 0, 0,        0, 0, 0,            1, 5, 32'hDEADBEEF, 1, 32'h20};
    tbl[2] = '{0, 0, 0,        0, 0, 0,            0, 0, 0,            0, 0};
    tbl[3] = '{1, 3, 32'h11,   1, 0, 32'h99,       1, 3, 32'h11,       0, 0};
    tbl[4] = '{1, 3, 32'h11,   0, 0, 0,            1, 3, 32'h11,       0, 0};
    tbl[5] = '{1, 0, 32'h55,   1, 7, 32'h42,       0, 0, 0,            0, 0};
    tbl[6] = '{1, 0, 32'h55,   0, 0, 0,            1, 7, 32'h42,       1, 32'h80};
    tbl[7] = '{0, 0, 0,        0, 0, 0,            0, 0, 0,            0, 0};

    do_reset();
    check("reset_ready", lu_ready, 1);
    check("reset_count", fifo_count, 0);

    // Directed vectors: no-bypass push, x0 discard, x0 pipeline slot.
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].pwe, tbl[i].prd, tbl[i].pwd, tbl[i].lv, tbl[i].lrd, tbl[i].lwd);
      check($sformatf("tbl%0d_we3", i), cap_we3, tbl[i].ewe);
      check($sformatf("tbl%0d_a3", i), cap_a3, tbl[i].ea);
      check($sformatf("tbl%0d_wd3", i), cap_wd3, tbl[i].ewd);
      check($sformatf("tbl%0d_cnt", i), cap_cnt, tbl[i].ecnt);
      check($sformatf("tbl%0d_pend", i), cap_pend, tbl[i].epend);
    end

    // Starvation: two entries behind continuous pipeline writes.
    do_reset();
    first_stall = -1;
    for (int c = 0; c < 20 && first_stall < 0; c++) begin
      cyc(1, 3, 32'h11, c < 2, (c == 0) ? 5'd9 : 5'd10, (c == 0) ? 32'hA : 32'hB);
      check("prio_a3", cap_a3, 3);
      if (c >= 2) check("prio_cnt", cap_cnt, 2);
      if (cap_stall) first_stall = c;
    end
    check("stall_cycle", first_stall, 9);
    cyc(0, 0, 0, 0, 0, 0);
    check("bubble_a3", cap_a3, 9);
    check("bubble_wd3", cap_wd3, 32'hA);
    cyc(1, 3, 32'h11, 0, 0, 0);
    check("stall_clear", cap_stall, 0);
    check("after_bubble_cnt", cap_cnt, 1);

    // Full FIFO, blocked push during pop, then push+pop with order kept.
    idle();
    for (int i = 1; i <= 4; i++) cyc(1, 3, 32'h11, 1, 5'(i), 32'h100 + i);
    cyc(1, 3, 32'h11, 0, 0, 0);
    check("full_ready", cap_rdy, 0);
    check("full_cnt", cap_cnt, 4);
    cyc(0, 0, 0, 1, 20, 32'h200);
    check("full_pop_ready", cap_rdy, 0);
    check("full_pop_a3", cap_a3, 1);
    cyc(0, 0, 0, 1, 21, 32'h201);
    check("reopen_ready", cap_rdy, 1);
    check("reopen_cnt", cap_cnt, 3);
    cyc(1, 3, 32'h11, 0, 0, 0);
    check("pushpop_cnt", cap_cnt, 3);
    idle(); check("order0", cap_a3, 3);
    idle(); check("order1", cap_a3, 4);
    idle(); check("order2", cap_a3, 21);
    check("order2_wd", cap_wd3, 32'h201);

    // Reset mid-operation with three entries queued.
    for (int i = 0; i < 3; i++) cyc(1, 3, 32'h11, 1, 5'(11 + i), 32'h300 + i);
    pipe_we = 1; pipe_rd = 6; pipe_wd = 32'h66; lu_valid = 0;
    #2 rst_n = 0;
    #1;
    check("rst_pend", pend_mask, 0);
    check("rst_cnt", fifo_count, 0);
    check("rst_we3", we3, 0);
    check("rst_a3", a3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_ready", lu_ready, 0);
    check("rst_stall", stall_req, 0);
    @(posedge clk); #1;
    check("rst_hold_we3", we3, 0);
    #2 rst_n = 1;
    q.delete(); starve = 0;
    #1 check("rel_ready", lu_ready, 1);
    @(posedge clk); #1;
    idle();
    check("rel_no_stale", cap_we3, 0);

    // Randomized traffic against the model; bubbles honour stall_req.
    for (int n = 0; n < 400; n++) begin
      logic pwe;
      logic [4:0] prd, lrd;
      pwe = ($urandom_range(0, 3) != 0) && !stall_req;
      prd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cyc(pwe, prd, $urandom, $urandom_range(0, 1) == 1, lrd, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
